// File: rtl/sdpb_rd_pkg.sv
// Shared definitions for the simple dual-port BRAM stream reader:
// controller state encoding, default widths and the read-credit rule.
package sdpb_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

    localparam int SDPB_ADDR_W = 8;
    localparam int SDPB_DATA_W = 18;

    // A read may issue only if the skid buffer still has a free slot once
    // every word already on its way has landed.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       pop);
        return (int'(occ) + int'(inflight) - int'(pop)) < 2;
    endfunction

endpackage

// File: rtl/sdpb_rd_skid.sv
// Two-entry FIFO holding {last, data} words captured from BRAM port B.
// The parent's credit rule guarantees it never overflows.
module sdpb_rd_skid #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [1:0]   occ_q, occ_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;

    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) slot0_d = push_data;
                    else               slot1_d = push_data;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    occ_d   = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes behind whatever remains.
                    if (occ_q == 2'd2) begin
                        slot0_d = slot1_q;
                        slot1_d = push_data;
                    end else begin
                        slot0_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign occ  = occ_q;
    assign head = slot0_q;

endmodule

// File: rtl/sdpb_stream_reader.sv
// Port-B read controller for the 256x18 simple dual-port BRAM: turns a
// {base, length} command into a valid/ready stream with a last marker.
module sdpb_stream_reader
    import sdpb_rd_pkg::*;
#(
    parameter int ADDR_W = SDPB_ADDR_W,
    parameter int DATA_W = SDPB_DATA_W,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] adb,
    output logic              ceb,
    output logic              oce,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic              pop, issue, flush, push;
    logic [1:0]        occ;
    logic [DATA_W:0]   head;

    always_comb begin
        pop   = out_valid && out_ready;
        issue = (state_q == ST_RUN) && (rem_q != '0) && !abort
                && credit_ok(occ, inflight_q, pop);

        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == LEN_W'(1));
        flush           = 1'b0;

        if (abort) begin
            // Drop everything in flight; the dout arriving next cycle is ignored.
            state_d         = ST_IDLE;
            busy_d          = 1'b0;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
            flush           = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d = base_addr;
                        rem_d  = length;
                        if (length == '0) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_d = addr_q + ADDR_W'(1);
                        rem_d  = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (pop && out_last) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        push = inflight_q && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    sdpb_rd_skid #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({inflight_last_q, dout}),
        .pop       (pop),
        .flush     (flush),
        .occ       (occ),
        .head      (head)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign adb       = addr_q;
    assign ceb       = issue;
    assign oce       = 1'b1;
    assign out_valid = (occ != 2'd0);
    assign out_data  = head[DATA_W-1:0];
    assign out_last  = out_valid && head[DATA_W];

endmodule
